// File: rtl/shift_pkg.sv
// Shared constants for the shift request queue: default widths, mode codes and FSM states.
package shift_pkg;

   localparam int DEF_DW    = 8;
   localparam int DEF_SW    = 3;
   localparam int DEF_DEPTH = 4;

   localparam logic MODE_LSL = 1'b0;
   localparam logic MODE_ROL = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      STALL  = 2'd2
   } state_t;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rls.sv
// 8-bit combinational barrel shifter: P=0 logical shift-left with zero fill, P=1 rotate-left.
module rls (
   input  logic [7:0] I,
   input  logic [2:0] S,
   input  logic       P,
   output logic [7:0] O
);

   logic [7:0] st1;
   logic [7:0] st2;

   // Three log-stages of 1, 2 and 4 positions; bits shifted out wrap back in only when rotating.
   always_comb begin
      st1 = S[0] ? {I[6:0],   (P ? I[7]     : 1'b0)}    : I;
      st2 = S[1] ? {st1[5:0], (P ? st1[7:6] : 2'b00)}   : st1;
      O   = S[2] ? {st2[3:0], (P ? st2[7:4] : 4'b0000)} : st2;
   end

endmodule

// File: rtl/shift_req_fifo.sv
// Synchronous request FIFO with occupancy count, full/empty flags and a synchronous flush.
module shift_req_fifo
   import shift_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = DEF_DW + DEF_SW + 1,
   parameter int CW    = cnt_width(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_en;
   logic          pop_en;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_en = push && !full && !flush;
   assign pop_en  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= wdata;
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/shift_req_queue.sv
// Buffered valid/ready front-end for the rls barrel shifter.
// Define SHIFT_STATS_EN to add the saturating op_count handshake counter port.
module shift_req_queue
   import shift_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int SW    = DEF_SW,
   parameter int DEPTH = DEF_DEPTH
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [SW-1:0] in_amt,
   input  logic          in_mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_mode,
   input  logic          flush
`ifdef SHIFT_STATS_EN
   ,
   output logic [15:0]   op_count
`endif
);

   localparam int EW = DW + SW + 1;
   localparam int CW = cnt_width(DEPTH);

   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [EW-1:0] head;
   logic [DW-1:0] shift_out;
   state_t        state;
   state_t        state_next;

   // in_ready comes only from the registered FIFO count, never from out_ready.
   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready && !flush;
   assign pop      = !fifo_empty && (!out_valid || out_ready) && !flush;

   shift_req_fifo #(
      .DEPTH (DEPTH),
      .W     (EW),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata ({in_mode, in_amt, in_data}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   rls u_rls (
      .I (head[DW-1:0]),
      .S (head[DW+SW-1:DW]),
      .P (head[EW-1]),
      .O (shift_out)
   );

   // Result register: loads on pop, holds while stalled, empties on handshake or flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mode  <= MODE_LSL;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= shift_out;
         out_mode  <= head[EW-1];
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Pipeline activity tracker; returns to IDLE once nothing is queued or held.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (push) state_next = ACTIVE;
         ACTIVE: begin
            if (out_valid && !out_ready)           state_next = STALL;
            else if (fifo_count == '0 && !push)    state_next = IDLE;
         end
         STALL:   if (out_ready) state_next = ACTIVE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

`ifdef SHIFT_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         op_count <= '0;
      else if (out_valid && out_ready && op_count != 16'hFFFF)
         op_count <= op_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_shift_req_queue.sv
// Randomised scoreboard bench for shift_req_queue; op_count is checked when SHIFT_STATS_EN is defined.
module tb_shift_req_queue;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_amt;
   logic       in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_mode;
   logic       flush;
`ifdef SHIFT_STATS_EN
   logic [15:0] op_count;
`endif

   int         total;
   int         bad;
   int         hs_count;
   logic [8:0] exp_q [$];
   logic       prev_stall;
   logic [8:0] prev_out;
   logic       disrupt;

   shift_req_queue dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mode  (out_mode),
      .flush     (flush)
`ifdef SHIFT_STATS_EN
      ,
      .op_count  (op_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: shift as arithmetic on a wide integer, wrapping the overflow back for rotate.
   function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] a, input logic m);
      int unsigned x;
      x = 32'(d) << a;
      if (m) return 8'((x & 32'hFF) | (x >> 8));
      else   return 8'(x & 32'hFF);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [2:0] a,
                                input logic m, input logic fl, output logic acc);
      in_valid = v;
      in_data  = d;
      in_amt   = a;
      in_mode  = m;
      flush    = fl;
      acc      = v && in_ready && !fl;
      if (acc) exp_q.push_back({m, ref_shift(d, a, m)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      logic acc;
      int   n;
      out_ready = 1'b1;
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, acc);
      n = 0;
      while ((out_valid || exp_q.size() != 0) && n < 20) begin
         tick();
         n++;
      end
      checkOutput({name, "_queue_empty"}, exp_q.size(), 0);
      checkOutput({name, "_idle"}, out_valid, 1'b0);
   endtask

   // Monitor: pops the scoreboard on every handshake and checks stall stability.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !disrupt) begin
            checkOutput("stall_valid", out_valid, 1'b1);
            checkOutput("stall_hold", {out_mode, out_data}, prev_out);
         end
         disrupt = 1'b0;
         if (out_valid && out_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_result actual=%0h required=none", {out_mode, out_data});
            end else begin
               checkOutput("result", {out_mode, out_data}, exp_q.pop_front());
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_mode, out_data};
      end
   end

   initial begin
      logic acc;
      int   acc_n;
      logic fl;

      total = 0; bad = 0; hs_count = 0;
      prev_stall = 1'b0; disrupt = 1'b0; prev_out = '0;
      rst = 1'b1; out_ready = 1'b0;
      in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = 1'b0; flush = 1'b0;
      #2;
      checkOutput("reset_in_ready", in_ready, 1'b1);
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_out_data", out_data, 8'h00);
      checkOutput("reset_out_mode", out_mode, 1'b0);
`ifdef SHIFT_STATS_EN
      checkOutput("reset_op_count", op_count, 16'd0);
`endif
      tick();
      rst = 1'b0;
      tick();

      // Single logical shift with latency check
      out_ready = 1'b1;
      applyStimulus(1'b1, 8'hB2, 3'd5, 1'b0, 1'b0, acc);
      tick();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, acc);
      checkOutput("lat_edge_k", out_valid, 1'b0);
      tick();
      checkOutput("lat_edge_k1", out_valid, 1'b1);
      checkOutput("lsl_data", out_data, 8'h40);
      checkOutput("lsl_mode", out_mode, 1'b0);
      tick();
      checkOutput("lsl_consumed", out_valid, 1'b0);

      // Rotates, back to back
      applyStimulus(1'b1, 8'hB2, 3'd5, 1'b1, 1'b0, acc);
      tick();
      applyStimulus(1'b1, 8'h81, 3'd1, 1'b1, 1'b0, acc);
      tick();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, acc);
      checkOutput("rol_data_a", out_data, 8'h56);
      checkOutput("rol_mode_a", out_mode, 1'b1);
      tick();
      checkOutput("rol_data_b", out_data, 8'h03);
      tick();
      checkOutput("rol_consumed", out_valid, 1'b0);

      // Amount zero passes data through in both modes
      applyStimulus(1'b1, 8'h5A, 3'd0, 1'b0, 1'b0, acc);
      tick();
      applyStimulus(1'b1, 8'hC3, 3'd0, 1'b1, 1'b0, acc);
      tick();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, acc);
      checkOutput("amt0_lsl", out_data, 8'h5A);
      tick();
      checkOutput("amt0_rol", out_data, 8'hC3);
      drain("amt0");

      // Backpressure: FIFO plus result register fill, then drain one per clock
      out_ready = 1'b0;
      acc_n = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b0, acc);
         if (acc) acc_n++;
         tick();
      end
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, acc);
      checkOutput("bp_accepted", acc_n, DEPTH + 1);
      checkOutput("bp_in_ready", in_ready, 1'b0);
      checkOutput("bp_out_valid", out_valid, 1'b1);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         checkOutput("bp_release_valid", out_valid, 1'b1);
         tick();
      end
      checkOutput("bp_release_done", out_valid, 1'b0);
      drain("bp");

      // Streaming with no bubbles
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checkOutput("stream_in_ready", in_ready, 1'b1);
         if (i >= 2) checkOutput("stream_no_bubble", out_valid, 1'b1);
         applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b0, acc);
         tick();
      end
      drain("stream");

      // Flush with a stalled result and queued requests; push during flush is dropped
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b0, acc);
         tick();
      end
      checkOutput("flush_pre_valid", out_valid, 1'b1);
      applyStimulus(1'b1, 8'hFF, 3'd1, 1'b0, 1'b1, acc);
      tick();
      disrupt = 1'b1;
      exp_q.delete();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, acc);
      checkOutput("flush_out_valid", out_valid, 1'b0);
      checkOutput("flush_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      tick();
      checkOutput("flush_dropped_push", out_valid, 1'b0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'b0, acc);
         tick();
      end
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      hs_count = 0;
      checkOutput("arst_out_valid", out_valid, 1'b0);
      checkOutput("arst_out_data", out_data, 8'h00);
      checkOutput("arst_out_mode", out_mode, 1'b0);
      checkOutput("arst_in_ready", in_ready, 1'b1);
`ifdef SHIFT_STATS_EN
      checkOutput("arst_op_count", op_count, 16'd0);
`endif
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, acc);
      tick();
      tick();
      rst = 1'b0;
      tick();
      checkOutput("post_rst_valid", out_valid, 1'b0);

      // Randomised traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         fl = ($urandom_range(0, 49) == 0);
         out_ready = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
         applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
                       1'($urandom), fl, acc);
         tick();
         if (fl) begin
            disrupt = 1'b1;
            exp_q.delete();
         end
      end
      drain("random");

`ifdef SHIFT_STATS_EN
      checkOutput("op_count", op_count, 16'(hs_count));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
